// File: rtl/uart_cmd_parser.sv
// ASCII write-command parser for "W<addr hex><data hex><CR>" frames from a UART RX byte stream.
// Optional ack byte outputs ('K' on write, '!' on error) are compiled in when UART_CMD_ACK_EN is defined.
module uart_cmd_parser #(
    parameter int WORDSZ         = 8,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_break,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORDSZ-1:0] wr_data,
    output logic              err,
    output logic [7:0]        frame_cnt,
    output logic [3:0]        state
`ifdef UART_CMD_ACK_EN
    ,
    output logic              ack_valid,
    output logic [7:0]        ack_data
`endif
);

    localparam int ADDR_DIGITS = ADDR_W / 4;
    localparam int DATA_DIGITS = WORDSZ / 4;
    localparam int MAX_DIGITS  = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
    localparam int CNT_W       = $clog2(MAX_DIGITS + 1);
    localparam int TO_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST     = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_ADDR    = 4'b0010,
        S_DATA    = 4'b0100,
        S_WAIT_CR = 4'b1000
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] acc_addr_reg;
    logic [WORDSZ-1:0] acc_data_reg;
    logic [CNT_W-1:0]  digit_cnt_reg;
    logic [TO_W-1:0]   tcnt_reg;

    logic       is_hex;
    logic [3:0] nibble;
    logic       is_w;
    logic       is_blank;
    logic       is_cr;
    logic       frame_error;
    logic       frame_done;

    assign state    = state_reg;
    assign is_w     = (rx_data == 8'h57) || (rx_data == 8'h77);
    assign is_cr    = (rx_data == CH_CR);
    assign is_blank = is_cr || (rx_data == CH_LF) || (rx_data == CH_SPACE);

    // Letters A-F / a-f share low bits 1..6, so +9 maps them onto 10..15.
    always_comb begin
        is_hex = 1'b1;
        nibble = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            nibble = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            nibble = rx_data[3:0] + 4'd9;
        end else begin
            is_hex = 1'b0;
        end
    end

    // Event decode: break beats a simultaneous byte, and a byte beats a timeout expiring in the same cycle.
    always_comb begin
        frame_error = 1'b0;
        frame_done  = 1'b0;
        if (rx_break) begin
            frame_error = (state_reg != S_IDLE);
        end else if (rx_valid) begin
            case (state_reg)
                S_IDLE:         frame_error = !(is_w || is_blank);
                S_ADDR, S_DATA: frame_error = !is_hex;
                S_WAIT_CR: begin
                    frame_done  = is_cr;
                    frame_error = !is_cr;
                end
                default:        frame_error = 1'b0;
            endcase
        end else if (TIMEOUT_CYCLES != 0 && state_reg != S_IDLE &&
                     tcnt_reg == TO_W'(TO_LAST)) begin
            frame_error = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= S_IDLE;
            acc_addr_reg  <= '0;
            acc_data_reg  <= '0;
            digit_cnt_reg <= '0;
            tcnt_reg      <= '0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            err           <= 1'b0;
            frame_cnt     <= 8'd0;
        end else begin
            wr_en <= frame_done;
            err   <= frame_error;

            if (rx_valid || rx_break || state_reg == S_IDLE || frame_error) begin
                tcnt_reg <= '0;
            end else if (TIMEOUT_CYCLES != 0) begin
                tcnt_reg <= tcnt_reg + 1'b1;
            end

            if (frame_error) begin
                // Accumulators deliberately keep their contents; the next 'W' clears them.
                state_reg <= S_IDLE;
            end else if (rx_valid && !rx_break) begin
                case (state_reg)
                    S_IDLE: begin
                        if (is_w) begin
                            state_reg     <= S_ADDR;
                            acc_addr_reg  <= '0;
                            acc_data_reg  <= '0;
                            digit_cnt_reg <= '0;
                        end
                    end
                    S_ADDR: begin
                        acc_addr_reg <= ADDR_W'({acc_addr_reg, nibble});
                        if (digit_cnt_reg == CNT_W'(ADDR_DIGITS - 1)) begin
                            state_reg     <= S_DATA;
                            digit_cnt_reg <= '0;
                        end else begin
                            digit_cnt_reg <= digit_cnt_reg + 1'b1;
                        end
                    end
                    S_DATA: begin
                        acc_data_reg <= WORDSZ'({acc_data_reg, nibble});
                        if (digit_cnt_reg == CNT_W'(DATA_DIGITS - 1)) begin
                            state_reg     <= S_WAIT_CR;
                            digit_cnt_reg <= '0;
                        end else begin
                            digit_cnt_reg <= digit_cnt_reg + 1'b1;
                        end
                    end
                    S_WAIT_CR: begin
                        state_reg <= S_IDLE;
                        wr_addr   <= acc_addr_reg;
                        wr_data   <= acc_data_reg;
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end else if (state_reg != S_IDLE && state_reg != S_ADDR &&
                         state_reg != S_DATA && state_reg != S_WAIT_CR) begin
                state_reg <= S_IDLE;
            end
        end
    end

`ifdef UART_CMD_ACK_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ack_valid <= 1'b0;
            ack_data  <= 8'h00;
        end else begin
            ack_valid <= frame_done || frame_error;
            if (frame_done) begin
                ack_data <= 8'h4B;
            end else if (frame_error) begin
                ack_data <= 8'h21;
            end
        end
    end
`endif

endmodule
